// File: rtl/sram_resp_pkg.sv
// rtl/sram_resp_pkg.sv - shared types and constants for the SRAM responder
package sram_resp_pkg;

    localparam int SRAM_AW = 19;
    localparam int SRAM_DW = 8;
    localparam int CNT_W   = 16;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WR_ACTIVE = 2'd1,
        RD_WAIT   = 2'd2,
        RD_VALID  = 2'd3
    } stateT;

    // Saturating increment for the access counters.
    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] value);
        return (value == {CNT_W{1'b1}}) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/sram_resp_array.sv
// rtl/sram_resp_array.sv - single-port synchronous RAM with registered read
module sram_resp_array
    import sram_resp_pkg::*;
#(
    parameter int AW = 8
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               wrEn,
    input  logic               rdEn,
    input  logic [AW-1:0]      addr,
    input  logic [SRAM_DW-1:0] wrData,
    output logic [SRAM_DW-1:0] rdData
);

    logic [SRAM_DW-1:0] mem [0:(2**AW)-1];

    // Write port; contents survive reset.
    always_ff @(posedge Clock) begin
        if (wrEn) begin
            mem[addr] <= wrData;
        end
    end

    // Read register only loads on rdEn, so it also serves as the held read-data output.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            rdData <= '0;
        end else if (rdEn) begin
            rdData <= mem[addr];
        end
    end

endmodule

// File: rtl/sram_responder.sv
// rtl/sram_responder.sv - device-side model of an asynchronous SRAM port
module sram_responder
    import sram_resp_pkg::*;
#(
    parameter int MEM_AW        = 8,
    parameter int READ_LATENCY  = 2,
    parameter int MIN_WE_CYCLES = 2
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic [SRAM_AW-1:0] iSramAddr,
    input  logic [SRAM_DW-1:0] iSramData,
    input  logic               iSramCe,
    input  logic               iSramWe,
    input  logic               iSramOe,
    output logic [SRAM_DW-1:0] oRdData,
    output logic               oRdValid,
    output logic [CNT_W-1:0]   oWrCount,
    output logic [CNT_W-1:0]   oRdCount,
    output logic               oProtoErr
);

    // The qualifying cycle counts as the first cycle of both counters.
    localparam logic [2:0] LAT_LAST = 3'(READ_LATENCY - 1);
    localparam logic [2:0] WE_MIN   = 3'(MIN_WE_CYCLES);

    logic               sCe, sWe, sOe;
    logic [SRAM_AW-1:0] sAddr;
    logic [SRAM_DW-1:0] sData;

    stateT              state, nextState;
    logic [SRAM_AW-1:0] latAddr;
    logic [SRAM_DW-1:0] wrData;
    logic [2:0]         weCnt, latCnt;

    logic allLow, addrMoved;
    logic wrStart, wrHold, commit, rdStart, latStep, rdFire, errHit;

    // Input stage: every decision below uses these registered strobes.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            sCe   <= 1'b1;
            sWe   <= 1'b1;
            sOe   <= 1'b1;
            sAddr <= '0;
            sData <= '0;
        end else begin
            sCe   <= iSramCe;
            sWe   <= iSramWe;
            sOe   <= iSramOe;
            sAddr <= iSramAddr;
            sData <= iSramData;
        end
    end

    assign allLow    = !sCe && !sWe && !sOe;
    assign addrMoved = (sAddr != latAddr);

    // State register.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state and per-cycle action decode.
    always_comb begin
        nextState = state;
        wrStart   = 1'b0;
        wrHold    = 1'b0;
        commit    = 1'b0;
        rdStart   = 1'b0;
        latStep   = 1'b0;
        rdFire    = 1'b0;
        errHit    = 1'b0;
        case (state)
            IDLE: begin
                if (allLow) begin
                    errHit = 1'b1;
                end else if (!sCe && !sWe) begin
                    wrStart   = 1'b1;
                    nextState = WR_ACTIVE;
                end else if (!sCe && !sOe) begin
                    rdStart = 1'b1;
                    if (READ_LATENCY == 1) begin
                        rdFire    = 1'b1;
                        nextState = RD_VALID;
                    end else begin
                        nextState = RD_WAIT;
                    end
                end
            end
            WR_ACTIVE: begin
                if (allLow || (sCe && !sWe)) begin
                    errHit    = 1'b1;
                    nextState = IDLE;
                end else if (sWe) begin
                    if (weCnt >= WE_MIN) begin
                        commit = 1'b1;
                    end else begin
                        errHit = 1'b1;
                    end
                    nextState = IDLE;
                end else if (addrMoved) begin
                    errHit    = 1'b1;
                    nextState = IDLE;
                end else begin
                    wrHold = 1'b1;
                end
            end
            RD_WAIT: begin
                if (allLow) begin
                    errHit    = 1'b1;
                    nextState = IDLE;
                end else if (sCe || sOe || !sWe) begin
                    nextState = IDLE;
                end else if (addrMoved) begin
                    rdStart = 1'b1;
                end else if (latCnt >= LAT_LAST) begin
                    rdFire    = 1'b1;
                    nextState = RD_VALID;
                end else begin
                    latStep = 1'b1;
                end
            end
            RD_VALID: begin
                if (allLow) begin
                    errHit    = 1'b1;
                    nextState = IDLE;
                end else if (sCe || sOe || !sWe) begin
                    nextState = IDLE;
                end else if (addrMoved) begin
                    rdStart   = 1'b1;
                    nextState = RD_WAIT;
                end
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // Access bookkeeping: latched address/data and the WE and latency counters.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            latAddr <= '0;
            wrData  <= '0;
            weCnt   <= '0;
            latCnt  <= '0;
        end else begin
            if (wrStart || rdStart) begin
                latAddr <= sAddr;
            end
            if (wrStart || wrHold) begin
                wrData <= sData;
            end
            if (wrStart) begin
                weCnt <= 3'd1;
            end else if (wrHold && weCnt != 3'd7) begin
                weCnt <= weCnt + 3'd1;
            end
            if (rdStart) begin
                latCnt <= 3'd1;
            end else if (latStep && latCnt != 3'd7) begin
                latCnt <= latCnt + 3'd1;
            end
        end
    end

    // Counters saturate; the error flag is sticky until reset.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            oWrCount  <= '0;
            oRdCount  <= '0;
            oProtoErr <= 1'b0;
        end else begin
            if (commit) begin
                oWrCount <= satInc(oWrCount);
            end
            if (rdFire) begin
                oRdCount <= satInc(oRdCount);
            end
            if (errHit) begin
                oProtoErr <= 1'b1;
            end
        end
    end

    assign oRdValid = (state == RD_VALID);

    // Writes use the latched address; reads fire only while sAddr matches the read target.
    sram_resp_array #(
        .AW(MEM_AW)
    ) uArray (
        .Clock  (Clock),
        .Reset  (Reset),
        .wrEn   (commit),
        .rdEn   (rdFire),
        .addr   (commit ? latAddr[MEM_AW-1:0] : sAddr[MEM_AW-1:0]),
        .wrData (wrData),
        .rdData (oRdData)
    );

endmodule
